controle_venda_param: RTL and testbench
=======================================

CONTROLE_VENDA_PARAM -- requirements
Module: controle_venda_param

Parameters
REQ-001 SHALL have parameter COD_W, default 4: product code width.
REQ-002 SHALL have parameter PRECO_W, default 8: price/coin value width; credit register is PRECO_W+1 bits.
REQ-003 SHALL have parameter TIMEOUT, default 1000: COMPARADOR inactivity limit in clk cycles, >=2.

Interface
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port codigo_digitado  input  1  one-cycle pulse, code entered.
REQ-007 SHALL have port codigo  input  COD_W  code, sampled when codigo_digitado=1.
REQ-008 SHALL have port codigo_reg  output  COD_W  registered code, drives external lookup.
REQ-009 SHALL have port existe_produto  input  1  combinational lookup result for codigo_reg.
REQ-010 SHALL have port preco  input  PRECO_W  price of codigo_reg, valid with existe_produto.
REQ-011 SHALL have port moeda_valida  input  1  one-cycle pulse, coin inserted.
REQ-012 SHALL have port moeda_valor  input  PRECO_W  coin value, sampled with moeda_valida.
REQ-013 SHALL have port cancelar  input  1  one-cycle pulse, user cancel.
REQ-014 SHALL have port libera  output  1  dispense request, held until acknowledged.
REQ-015 SHALL have port libera_ack  input  1  dispenser acknowledge.
REQ-016 SHALL have port troco_valido  output  1  one-cycle pulse, change/refund amount valid.
REQ-017 SHALL have port troco_valor  output  PRECO_W+1  change/refund amount.
REQ-018 SHALL have port moeda_rejeitada  output  1  one-cycle pulse, coin ignored.
REQ-019 SHALL have port estados  output  3  registered current state code.

Function
REQ-020 SHALL encode states ESPERA=000, PRODUTO=001, COMPARADOR=010, DISPENSA=011, TROCO=100; codes 101-111 SHALL return to ESPERA on the next edge.
REQ-021 ESPERA: on codigo_digitado SHALL latch codigo into codigo_reg and enter PRODUTO; credit held at 0.
REQ-022 PRODUTO (exactly one cycle): existe_produto=1 SHALL latch preco into preco_reg and enter COMPARADOR; else return to ESPERA.
REQ-023 COMPARADOR: moeda_valida SHALL add moeda_valor to credit, saturating at 2^(PRECO_W+1)-1.
REQ-024 COMPARADOR: when registered credit >= preco_reg SHALL enter DISPENSA on the next edge (one-cycle compare latency after the coin).
REQ-025 COMPARADOR: cancelar SHALL enter TROCO with refund=credit; cancelar SHALL win over a same-cycle coin, which is still added to the refund.
REQ-026 COMPARADOR: timeout counter SHALL reset on entry and on each coin; reaching TIMEOUT-1 with no coin SHALL act as cancelar.
REQ-027 DISPENSA: libera SHALL be 1 for every cycle in DISPENSA; on libera_ack SHALL enter TROCO with change=credit-preco_reg.
REQ-028 TROCO (exactly one cycle): troco_valido SHALL pulse and troco_valor show the amount only if amount>0; SHALL clear credit and return to ESPERA.
REQ-029 preco_reg=0 SHALL dispense without any coin (DISPENSA one cycle after entering COMPARADOR).
REQ-030 moeda_valida outside COMPARADOR SHALL pulse moeda_rejeitada the next cycle and not change credit.
REQ-031 codigo_digitado and cancelar outside ESPERA/COMPARADOR respectively SHALL be ignored.
REQ-032 estados, libera, troco_valido, troco_valor, moeda_rejeitada SHALL be registered outputs.

Reset
REQ-033 rst_n=0 SHALL immediately force state ESPERA, estados=000, credit=0, codigo_reg=0, preco_reg=0, timer=0, libera=0, troco_valido=0, troco_valor=0, moeda_rejeitada=0.
REQ-034 Reset mid-transaction SHALL discard credit with no troco_valido pulse.

Verification
REQ-035 code 3, existe=1, preco=50; coins 20,20,20 -> DISPENSA, libera=1; ack -> troco_valido with troco_valor=10, then ESPERA.
REQ-036 code 5, existe_produto=0 -> PRODUTO one cycle, then ESPERA, no libera.
REQ-037 preco=50, coin 30, cancelar same cycle as coin 10 -> TROCO, troco_valor=40.
REQ-038 TIMEOUT=8, preco=50, coin 20, idle 8 cycles -> troco_valor=20, ESPERA.
REQ-039 PRECO_W=8, coins 255,255 with preco=255 -> credit 510, change 255; coin in ESPERA -> moeda_rejeitada.
REQ-040 rst_n low while libera=1 -> libera=0 and estados=000 asynchronously, no troco pulse.

Source files
------------

// File: rtl/controle_venda_param.sv
// Vending-machine sale controller: code entry, price lookup, coin credit,
// dispense handshake and change/refund reporting.
module controle_venda_param #(
    parameter int COD_W   = 4,
    parameter int PRECO_W = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               codigo_digitado,
    input  logic [COD_W-1:0]   codigo,
    output logic [COD_W-1:0]   codigo_reg,
    input  logic               existe_produto,
    input  logic [PRECO_W-1:0] preco,
    input  logic               moeda_valida,
    input  logic [PRECO_W-1:0] moeda_valor,
    input  logic               cancelar,
    output logic               libera,
    input  logic               libera_ack,
    output logic               troco_valido,
    output logic [PRECO_W:0]   troco_valor,
    output logic               moeda_rejeitada,
    output logic [2:0]         estados
);

    localparam int CRED_W = PRECO_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT);

    localparam logic [2:0] ESPERA     = 3'b000;
    localparam logic [2:0] PRODUTO    = 3'b001;
    localparam logic [2:0] COMPARADOR = 3'b010;
    localparam logic [2:0] DISPENSA   = 3'b011;
    localparam logic [2:0] TROCO      = 3'b100;

    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CRED_W-1:0] CRED_MAX = '1;

    logic [2:0]         state_q, state_d;
    logic [COD_W-1:0]   codigo_reg_q, codigo_reg_d;
    logic [PRECO_W-1:0] preco_reg_q, preco_reg_d;
    logic [CRED_W-1:0]  credit_q, credit_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               libera_q, libera_d;
    logic               troco_valido_q, troco_valido_d;
    logic [CRED_W-1:0]  troco_valor_q, troco_valor_d;
    logic               moeda_rejeitada_q, moeda_rejeitada_d;

    logic [CRED_W:0]    credit_sum;
    logic [CRED_W-1:0]  credit_add;
    logic [CRED_W-1:0]  preco_ext;
    logic [CRED_W-1:0]  amount;

    // Credit accumulates with saturation so a large coin can never wrap it.
    assign credit_sum = {1'b0, credit_q} + (CRED_W + 1)'(moeda_valor);
    assign credit_add = credit_sum[CRED_W] ? CRED_MAX : credit_sum[CRED_W-1:0];
    assign preco_ext  = {1'b0, preco_reg_q};

    always_comb begin
        state_d      = state_q;
        codigo_reg_d = codigo_reg_q;
        preco_reg_d  = preco_reg_q;
        credit_d     = credit_q;
        timer_d      = timer_q;
        amount       = '0;

        case (state_q)
            ESPERA: begin
                credit_d = '0;
                timer_d  = '0;
                if (codigo_digitado) begin
                    codigo_reg_d = codigo;
                    state_d      = PRODUTO;
                end
            end

            PRODUTO: begin
                timer_d = '0;
                if (existe_produto) begin
                    preco_reg_d = preco;
                    state_d     = COMPARADOR;
                end else begin
                    state_d = ESPERA;
                end
            end

            COMPARADOR: begin
                if (moeda_valida) begin
                    credit_d = credit_add;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end

                // Cancel beats everything; a coin in the same cycle still joins the refund.
                if (cancelar) begin
                    state_d = TROCO;
                    amount  = credit_d;
                end else if (credit_q >= preco_ext) begin
                    state_d = DISPENSA;
                end else if (!moeda_valida && timer_q == TMR_LAST) begin
                    state_d = TROCO;
                    amount  = credit_q;
                end
            end

            DISPENSA: begin
                if (libera_ack) begin
                    state_d = TROCO;
                    amount  = credit_q - preco_ext;
                end
            end

            TROCO: begin
                credit_d = '0;
                timer_d  = '0;
                state_d  = ESPERA;
            end

            default: begin
                credit_d = '0;
                timer_d  = '0;
                state_d  = ESPERA;
            end
        endcase
    end

    // Outputs are precomputed from the next state so they line up with estados.
    always_comb begin
        libera_d          = (state_d == DISPENSA);
        troco_valido_d    = (amount != '0);
        troco_valor_d     = amount;
        moeda_rejeitada_d = moeda_valida && (state_q != COMPARADOR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ESPERA;
            codigo_reg_q      <= '0;
            preco_reg_q       <= '0;
            credit_q          <= '0;
            timer_q           <= '0;
            libera_q          <= 1'b0;
            troco_valido_q    <= 1'b0;
            troco_valor_q     <= '0;
            moeda_rejeitada_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            codigo_reg_q      <= codigo_reg_d;
            preco_reg_q       <= preco_reg_d;
            credit_q          <= credit_d;
            timer_q           <= timer_d;
            libera_q          <= libera_d;
            troco_valido_q    <= troco_valido_d;
            troco_valor_q     <= troco_valor_d;
            moeda_rejeitada_q <= moeda_rejeitada_d;
        end
    end

    assign estados         = state_q;
    assign codigo_reg      = codigo_reg_q;
    assign libera          = libera_q;
    assign troco_valido    = troco_valido_q;
    assign troco_valor     = troco_valor_q;
    assign moeda_rejeitada = moeda_rejeitada_q;

endmodule

// File: tb/tb_controle_venda_param.sv
// Directed bench for controle_venda_param; change/refund pulses are checked
// by a scoreboard monitor against amounts queued by the stimulus.
module tb_controle_venda_param;

    localparam int COD_W   = 4;
    localparam int PRECO_W = 8;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               codigo_digitado = 1'b0;
    logic [COD_W-1:0]   codigo = '0;
    logic [COD_W-1:0]   codigo_reg;
    logic               existe_produto;
    logic [PRECO_W-1:0] preco;
    logic               moeda_valida = 1'b0;
    logic [PRECO_W-1:0] moeda_valor = '0;
    logic               cancelar = 1'b0;
    logic               libera;
    logic               libera_ack = 1'b0;
    logic               troco_valido;
    logic [PRECO_W:0]   troco_valor;
    logic               moeda_rejeitada;
    logic [2:0]         estados;

    int check_cnt = 0;
    int err_cnt   = 0;
    int exp_q[$];

    controle_venda_param #(
        .COD_W   (COD_W),
        .PRECO_W (PRECO_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .codigo_digitado (codigo_digitado),
        .codigo          (codigo),
        .codigo_reg      (codigo_reg),
        .existe_produto  (existe_produto),
        .preco           (preco),
        .moeda_valida    (moeda_valida),
        .moeda_valor     (moeda_valor),
        .cancelar        (cancelar),
        .libera          (libera),
        .libera_ack      (libera_ack),
        .troco_valido    (troco_valido),
        .troco_valor     (troco_valor),
        .moeda_rejeitada (moeda_rejeitada),
        .estados         (estados)
    );

    always #5 clk = ~clk;

    // Product catalogue seen by the controller through codigo_reg.
    always_comb begin
        existe_produto = 1'b0;
        preco          = '0;
        case (codigo_reg)
            4'd2, 4'd3: begin existe_produto = 1'b1; preco = 8'd50;  end
            4'd7:       begin existe_produto = 1'b1; preco = 8'd255; end
            4'd9:       begin existe_produto = 1'b1; preco = 8'd0;   end
            default:    begin existe_produto = 1'b0; preco = '0;     end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic dig, input logic [COD_W-1:0] cod,
                                 input logic mv, input logic [PRECO_W-1:0] mval,
                                 input logic canc, input logic ack);
        codigo_digitado = dig;
        codigo          = cod;
        moeda_valida    = mv;
        moeda_valor     = mval;
        cancelar        = canc;
        libera_ack      = ack;
        @(posedge clk);
        #1;
        codigo_digitado = 1'b0;
        moeda_valida    = 1'b0;
        moeda_valor     = '0;
        cancelar        = 1'b0;
        libera_ack      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    // Scoreboard monitor: every change pulse must match the oldest queued amount.
    initial begin
        forever begin
            @(negedge clk);
            if (troco_valido) begin
                check_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("[TB] FAIL troco_unexpected got=%0d expected=no_pulse at %0t", troco_valor, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (32'(troco_valor) != e) begin
                        err_cnt++;
                        $display("[TB] FAIL troco_valor got=%0d expected=%0d at %0t", troco_valor, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_estados", 32'(estados), 0);
        checkOutput("reset_libera", 32'(libera), 0);
        checkOutput("reset_troco_valido", 32'(troco_valido), 0);
        checkOutput("reset_troco_valor", 32'(troco_valor), 0);
        checkOutput("reset_rejeitada", 32'(moeda_rejeitada), 0);
        checkOutput("reset_codigo_reg", 32'(codigo_reg), 0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] sale with change");
        applyStimulus(1, 3, 0, 0, 0, 0);
        checkOutput("sale_produto", 32'(estados), 1);
        checkOutput("sale_codigo_reg", 32'(codigo_reg), 3);
        idle(1);
        checkOutput("sale_comparador", 32'(estados), 2);
        applyStimulus(0, 0, 1, 20, 0, 0);
        applyStimulus(0, 0, 1, 20, 0, 0);
        applyStimulus(0, 0, 1, 20, 0, 0);
        checkOutput("sale_still_comparing", 32'(estados), 2);
        idle(1);
        checkOutput("sale_dispensa", 32'(estados), 3);
        checkOutput("sale_libera", 32'(libera), 1);
        applyStimulus(0, 0, 1, 5, 0, 0);
        checkOutput("dispensa_coin_rejected", 32'(moeda_rejeitada), 1);
        checkOutput("dispensa_libera_held", 32'(libera), 1);
        exp_q.push_back(10);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("sale_troco_state", 32'(estados), 4);
        checkOutput("sale_libera_drop", 32'(libera), 0);
        idle(1);
        checkOutput("sale_back_espera", 32'(estados), 0);

        $display("[TB] unknown product");
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("noprod_produto", 32'(estados), 1);
        idle(1);
        checkOutput("noprod_espera", 32'(estados), 0);
        checkOutput("noprod_libera", 32'(libera), 0);

        $display("[TB] cancel with same-cycle coin");
        applyStimulus(1, 2, 0, 0, 0, 0);
        idle(1);
        applyStimulus(0, 0, 1, 30, 0, 0);
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("code_ignored_comparador", 32'(codigo_reg), 2);
        exp_q.push_back(40);
        applyStimulus(0, 0, 1, 10, 1, 0);
        checkOutput("cancel_troco_state", 32'(estados), 4);
        idle(1);
        checkOutput("cancel_espera", 32'(estados), 0);

        $display("[TB] inactivity timeout");
        applyStimulus(1, 2, 0, 0, 0, 0);
        idle(1);
        applyStimulus(0, 0, 1, 20, 0, 0);
        idle(7);
        checkOutput("timeout_not_yet", 32'(estados), 2);
        exp_q.push_back(20);
        idle(1);
        checkOutput("timeout_troco_state", 32'(estados), 4);
        idle(1);
        checkOutput("timeout_espera", 32'(estados), 0);

        $display("[TB] maximum coins and price");
        applyStimulus(1, 7, 0, 0, 0, 0);
        idle(1);
        applyStimulus(0, 0, 1, 255, 0, 0);
        applyStimulus(0, 0, 1, 255, 0, 0);
        checkOutput("max_dispensa", 32'(estados), 3);
        exp_q.push_back(255);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idle(1);
        applyStimulus(0, 0, 1, 9, 0, 0);
        checkOutput("espera_coin_rejected", 32'(moeda_rejeitada), 1);
        checkOutput("espera_coin_state", 32'(estados), 0);
        idle(1);
        checkOutput("rejeitada_one_cycle", 32'(moeda_rejeitada), 0);

        $display("[TB] free product");
        applyStimulus(1, 9, 0, 0, 0, 0);
        idle(1);
        checkOutput("free_comparador", 32'(estados), 2);
        idle(1);
        checkOutput("free_dispensa", 32'(estados), 3);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("free_troco_state", 32'(estados), 4);
        checkOutput("free_no_change", 32'(troco_valido), 0);
        idle(1);

        $display("[TB] reset during dispense");
        applyStimulus(1, 3, 0, 0, 0, 0);
        idle(1);
        applyStimulus(0, 0, 1, 30, 0, 0);
        applyStimulus(0, 0, 1, 30, 0, 0);
        idle(1);
        checkOutput("rst_pre_libera", 32'(libera), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_libera", 32'(libera), 0);
        checkOutput("rst_async_estados", 32'(estados), 0);
        checkOutput("rst_async_troco", 32'(troco_valido), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_after_estados", 32'(estados), 0);
        checkOutput("rst_after_troco", 32'(troco_valido), 0);
        idle(3);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
